platform_collider: RTL and testbench
====================================

# platform_collider

Frame-rate collision detector that produces the `collision` and `ground` inputs consumed by the doodle position/render block. Once per `frame_tick` it latches the doodle position and scans the platform list sequentially, one platform per clock. It reports whether the doodle's feet crossed a platform top while falling, and which platform. Results are held stable for a full frame, so the doodle block samples them on its next frame tick; this gives one frame of latency by design.

## Interface
- `NUM_PLATFORMS`, 8: number of platform slots scanned (1..32).
- `DOODLE_W`, 78: doodle hitbox width in px.
- `DOODLE_H`, 80: doodle height in px; feet = `doodle_y + DOODLE_H`.
- `PLAT_W`, 100: platform width in px.
- `FLOOR_Y`, 767: floor line; it acts as a full-width platform.

- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `frame_tick` in 1: one-cycle pulse per frame.
- `doodle_x` in 11: doodle left edge.
- `doodle_y` in 10: doodle top edge (y grows downward).
- `plat_x` in [NUM_PLATFORMS-1:0][10:0]: platform left edges.
- `plat_y` in [NUM_PLATFORMS-1:0][9:0]: platform top surfaces.
- `plat_valid` in NUM_PLATFORMS: slot enabled.
- `collision` out 1: landing detected in last completed scan (level, held).
- `ground` out [1:0][9:0]: `ground[0]` = landed surface y, `ground[1]` = landed platform x.
- `hit_index` out $clog2(NUM_PLATFORMS)+1: winning slot; value NUM_PLATFORMS = floor.
- `busy` out 1: scan in progress.

## Operation
- States: IDLE, SCAN, REPORT.
- IDLE → SCAN on `frame_tick`:
  - latch `cur_x` = `doodle_x` and `cur_y` = `doodle_y`;
  - keep previous-frame `prev_y`;
  - clear the best-candidate register; index counter = 0.
- SCAN: evaluate slot `idx` each cycle; after slot NUM_PLATFORMS-1, go to REPORT.
- Hit rule for slot i, all arithmetic in 12-bit unsigned:
  - `prev_valid` is set;
  - `cur_y > prev_y` (falling);
  - `plat_valid[i]`;
  - `prev_y+DOODLE_H <= plat_y[i] <= cur_y+DOODLE_H`;
  - `cur_x + DOODLE_W > plat_x[i]` and `cur_x < plat_x[i] + PLAT_W`.
- Multiple hits: the smallest `plat_y` wins (first surface crossed). On equal `plat_y`, the lowest index wins.
- Floor: if no platform hit, and falling, and `cur_y+DOODLE_H >= FLOOR_Y`, the floor hits with `ground = {0, FLOOR_Y}` and `hit_index = NUM_PLATFORMS`.
- REPORT (one cycle):
  - On a hit: `collision` = 1, `ground` = {winner x[9:0], winner y}, `hit_index` = winner.
  - On no hit: `collision` = 0, and `ground`/`hit_index` keep their previous values.
  - Then `prev_y` = `cur_y`, `prev_valid` = 1, next state IDLE.
- `frame_tick` while in SCAN or REPORT is ignored, with no queuing.
- Platform inputs are sampled live during SCAN; they must be held stable from tick until `busy` falls.

## Timing
- Reset values:
  - `collision` = 0, `ground` = {0, FLOOR_Y}, `hit_index` = NUM_PLATFORMS;
  - `busy` = 0, `prev_valid` = 0, state IDLE.
- Tick sampled at edge T. Slot k is evaluated in cycle T+1+k. REPORT is in cycle T+1+N, and outputs update at the edge ending it: visible from T+N+2.
- `busy` is high from T+1 through T+N+1.
- Back-to-back: the earliest accepted next tick is at T+N+2.
- The first scan after reset never reports a hit, because `prev_valid` = 0.
- `rst` mid-scan: immediate abort to IDLE, all outputs to reset values, the partial result is discarded.
- Equal `cur_y` and `prev_y` (hovering): not falling, so no collision.

## Structure
- Shared package `doodle_pkg` holds:
  - constants `DOODLE_W`, `DOODLE_H`, `PLAT_W`, `FLOOR_Y`, used as parameter defaults here and in the doodle block;
  - the state enum `collider_state_t`.
- Sub-module `platform_hit_check`: combinational per-slot comparator. Inputs: `cur_x`, `cur_y`, `prev_y`, `prev_valid`, `plat_x`, `plat_y`, `plat_valid`. Output: `hit`. It is instantiated once and fed through the index mux.

## Test plan
- Prime and land (N=8, slot 0 at x=400, y=500, `doodle_x`=420):
  - tick with `doodle_y`=400 → `collision`=0;
  - then tick with `doodle_y`=430 → `collision`=1, `ground`={400,500}, `hit_index`=0 at T+10, `busy` high T+1..T+9.
- Rising (same slot), `doodle_y` 430 then 400 → `collision`=0, and `ground` unchanged.
- Horizontal miss: `doodle_x`=300 (300+78=378 ≤ 400), falling across y=500 → `collision`=0.
- Priority: slot 3 y=495 and slot 1 y=505 both crossed (`doodle_y` 410→430) → `hit_index`=3, `ground[0]`=495.
  - Equal y in slots 2 and 5 → `hit_index`=2.
- Floor: no valid slots, `doodle_y` 680→690 → `collision`=1, `ground`={0,767}, `hit_index`=8.
- Robustness:
  - a second tick at T+4 → ignored, and the next scan starts only on a tick at or after T+10;
  - `rst` at T+5 → outputs at reset values, and the following tick reports no hit (re-priming).

Source files
------------

// File: rtl/doodle_pkg.sv
// Constants and types shared by the doodle position block and the platform collider.
package doodle_pkg;

    localparam int DOODLE_W = 78;
    localparam int DOODLE_H = 80;
    localparam int PLAT_W   = 100;
    localparam int FLOOR_Y  = 767;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_REPORT = 2'd2
    } collider_state_t;

endpackage

// File: rtl/platform_hit_check.sv
// Combinational landing test of the doodle against one platform slot.
module platform_hit_check
    import doodle_pkg::*;
#(
    parameter int P_DOODLE_W = DOODLE_W,
    parameter int P_DOODLE_H = DOODLE_H,
    parameter int P_PLAT_W   = PLAT_W
) (
    input  logic [10:0] i_cur_x,
    input  logic [9:0]  i_cur_y,
    input  logic [9:0]  i_prev_y,
    input  logic        i_prev_valid,
    input  logic [10:0] i_plat_x,
    input  logic [9:0]  i_plat_y,
    input  logic        i_plat_valid,
    output logic        o_hit
);

    logic [11:0] w_cur_x;
    logic [11:0] w_cur_y;
    logic [11:0] w_prev_y;
    logic [11:0] w_plat_x;
    logic [11:0] w_plat_y;
    logic [11:0] w_cur_feet;
    logic [11:0] w_prev_feet;
    logic [11:0] w_cur_right;
    logic [11:0] w_plat_right;

    assign w_cur_x      = {1'b0, i_cur_x};
    assign w_cur_y      = {2'b00, i_cur_y};
    assign w_prev_y     = {2'b00, i_prev_y};
    assign w_plat_x     = {1'b0, i_plat_x};
    assign w_plat_y     = {2'b00, i_plat_y};
    assign w_cur_feet   = w_cur_y + 12'(P_DOODLE_H);
    assign w_prev_feet  = w_prev_y + 12'(P_DOODLE_H);
    assign w_cur_right  = w_cur_x + 12'(P_DOODLE_W);
    assign w_plat_right = w_plat_x + 12'(P_PLAT_W);

    // Feet must have swept through the platform top during this frame's fall.
    assign o_hit = i_prev_valid && (w_cur_y > w_prev_y) && i_plat_valid &&
                   (w_prev_feet <= w_plat_y) && (w_plat_y <= w_cur_feet) &&
                   (w_cur_right > w_plat_x) && (w_cur_x < w_plat_right);

endmodule

// File: rtl/platform_collider.sv
// Per-frame sequential platform scan producing held collision/ground results.
module platform_collider
    import doodle_pkg::*;
#(
    parameter int NUM_PLATFORMS = 8,
    parameter int P_DOODLE_W    = DOODLE_W,
    parameter int P_DOODLE_H    = DOODLE_H,
    parameter int P_PLAT_W      = PLAT_W,
    parameter int P_FLOOR_Y     = FLOOR_Y,
    localparam int IDXW         = $clog2(NUM_PLATFORMS) + 1
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_frame_tick,
    input  logic [10:0]                     i_doodle_x,
    input  logic [9:0]                      i_doodle_y,
    input  logic [NUM_PLATFORMS-1:0][10:0]  i_plat_x,
    input  logic [NUM_PLATFORMS-1:0][9:0]   i_plat_y,
    input  logic [NUM_PLATFORMS-1:0]        i_plat_valid,
    output logic                            o_collision,
    output logic [1:0][9:0]                 o_ground,
    output logic [IDXW-1:0]                 o_hit_index,
    output logic                            o_busy
);

    collider_state_t r_state, w_state_nxt;

    logic [10:0]     r_cur_x;
    logic [9:0]      r_cur_y;
    logic [9:0]      r_prev_y;
    logic            r_prev_valid;
    logic [IDXW-1:0] r_idx;
    logic            r_best_found;
    logic [10:0]     r_best_x;
    logic [9:0]      r_best_y;
    logic [IDXW-1:0] r_best_idx;
    logic            r_collision;
    logic [9:0]      r_ground_y;
    logic [9:0]      r_ground_x;
    logic [IDXW-1:0] r_hit_index;

    logic [10:0]     w_sel_x;
    logic [9:0]      w_sel_y;
    logic            w_sel_valid;
    logic            w_hit;
    logic            w_last;
    logic            w_floor;

    always_comb begin
        w_sel_x     = '0;
        w_sel_y     = '0;
        w_sel_valid = 1'b0;
        for (int i = 0; i < NUM_PLATFORMS; i++) begin
            if (r_idx == IDXW'(i)) begin
                w_sel_x     = i_plat_x[i];
                w_sel_y     = i_plat_y[i];
                w_sel_valid = i_plat_valid[i];
            end
        end
    end

    platform_hit_check #(
        .P_DOODLE_W (P_DOODLE_W),
        .P_DOODLE_H (P_DOODLE_H),
        .P_PLAT_W   (P_PLAT_W)
    ) u_hit_check (
        .i_cur_x      (r_cur_x),
        .i_cur_y      (r_cur_y),
        .i_prev_y     (r_prev_y),
        .i_prev_valid (r_prev_valid),
        .i_plat_x     (w_sel_x),
        .i_plat_y     (w_sel_y),
        .i_plat_valid (w_sel_valid),
        .o_hit        (w_hit)
    );

    assign w_last  = (r_idx == IDXW'(NUM_PLATFORMS - 1));
    assign w_floor = r_prev_valid && (r_cur_y > r_prev_y) &&
                     (({2'b00, r_cur_y} + 12'(P_DOODLE_H)) >= 12'(P_FLOOR_Y));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (i_frame_tick) w_state_nxt = ST_SCAN;
            ST_SCAN:   if (w_last) w_state_nxt = ST_REPORT;
            ST_REPORT: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cur_x      <= '0;
            r_cur_y      <= '0;
            r_prev_y     <= '0;
            r_prev_valid <= 1'b0;
            r_idx        <= '0;
            r_best_found <= 1'b0;
            r_best_x     <= '0;
            r_best_y     <= '0;
            r_best_idx   <= '0;
            r_collision  <= 1'b0;
            r_ground_y   <= 10'(P_FLOOR_Y);
            r_ground_x   <= '0;
            r_hit_index  <= IDXW'(NUM_PLATFORMS);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_frame_tick) begin
                        r_cur_x      <= i_doodle_x;
                        r_cur_y      <= i_doodle_y;
                        r_idx        <= '0;
                        r_best_found <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    r_idx <= r_idx + 1'b1;
                    // Strict compare keeps the earlier (lower) slot on equal heights.
                    if (w_hit && (!r_best_found || (w_sel_y < r_best_y))) begin
                        r_best_found <= 1'b1;
                        r_best_x     <= w_sel_x;
                        r_best_y     <= w_sel_y;
                        r_best_idx   <= r_idx;
                    end
                end
                ST_REPORT: begin
                    if (r_best_found) begin
                        r_collision <= 1'b1;
                        r_ground_x  <= r_best_x[9:0];
                        r_ground_y  <= r_best_y;
                        r_hit_index <= r_best_idx;
                    end else if (w_floor) begin
                        r_collision <= 1'b1;
                        r_ground_x  <= '0;
                        r_ground_y  <= 10'(P_FLOOR_Y);
                        r_hit_index <= IDXW'(NUM_PLATFORMS);
                    end else begin
                        r_collision <= 1'b0;
                    end
                    r_prev_y     <= r_cur_y;
                    r_prev_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_collision = r_collision;
    assign o_ground[0] = r_ground_y;
    assign o_ground[1] = r_ground_x;
    assign o_hit_index = r_hit_index;
    assign o_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_platform_collider.sv
// Directed and randomized frames against a rule-level landing model.
module tb_platform_collider;

    localparam int N    = 8;
    localparam int IDXW = $clog2(N) + 1;

    logic                clk = 1'b0;
    logic                rst;
    logic                tick;
    logic [10:0]         doodle_x;
    logic [9:0]          doodle_y;
    logic [N-1:0][10:0]  plat_x;
    logic [N-1:0][9:0]   plat_y;
    logic [N-1:0]        plat_valid;
    logic                collision;
    logic [1:0][9:0]     ground;
    logic [IDXW-1:0]     hit_index;
    logic                busy;

    int checks = 0;
    int errors = 0;

    int m_prev_y, m_prev_valid, m_coll, m_g0, m_g1, m_hi;

    platform_collider #(.NUM_PLATFORMS(N)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_frame_tick (tick),
        .i_doodle_x   (doodle_x),
        .i_doodle_y   (doodle_y),
        .i_plat_x     (plat_x),
        .i_plat_y     (plat_y),
        .i_plat_valid (plat_valid),
        .o_collision  (collision),
        .o_ground     (ground),
        .o_hit_index  (hit_index),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_prev_y     = 0;
        m_prev_valid = 0;
        m_coll       = 0;
        m_g0         = 767;
        m_g1         = 0;
        m_hi         = N;
    endtask

    task automatic model_frame(input int cx, input int cy);
        int  best;
        int  by;
        bit  falling;
        falling = (m_prev_valid != 0) && (cy > m_prev_y);
        best = -1;
        by   = 0;
        for (int i = 0; i < N; i++) begin
            int px, py;
            px = int'(plat_x[i]);
            py = int'(plat_y[i]);
            if (falling && plat_valid[i] &&
                m_prev_y + 80 <= py && py <= cy + 80 &&
                cx + 78 > px && cx < px + 100) begin
                if (best < 0 || py < by) begin
                    best = i;
                    by   = py;
                end
            end
        end
        if (best >= 0) begin
            m_coll = 1;
            m_g0   = by;
            m_g1   = int'(plat_x[best]) % 1024;
            m_hi   = best;
        end else if (falling && cy + 80 >= 767) begin
            m_coll = 1;
            m_g0   = 767;
            m_g1   = 0;
            m_hi   = N;
        end else begin
            m_coll = 0;
        end
        m_prev_y     = cy;
        m_prev_valid = 1;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".collision"}, int'(collision), m_coll);
        check({tag, ".ground0"},   int'(ground[0]), m_g0);
        check({tag, ".ground1"},   int'(ground[1]), m_g1);
        check({tag, ".hit_index"}, int'(hit_index), m_hi);
    endtask

    // Cycle k (1-based after the tick edge) is observed at its falling edge.
    task automatic run_frame(input string tag, input int cx, input int cy,
                             input int extra_tick, input int rst_at);
        doodle_x = 11'(cx);
        doodle_y = 10'(cy);
        @(negedge clk);
        tick = 1'b1;
        model_frame(cx, cy);
        for (int k = 1; k <= N + 3; k++) begin
            @(negedge clk);
            tick = (k == extra_tick);
            if (k == rst_at) begin
                rst = 1'b1;
                #1;
                model_reset();
                check_outputs({tag, ".rst"});
                check({tag, ".rst_busy"}, int'(busy), 0);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            check($sformatf("%s.busy%0d", tag, k), int'(busy), (k <= N + 1) ? 1 : 0);
            if (k == N + 2) check_outputs(tag);
        end
    endtask

    task automatic clear_plats();
        plat_x     = '0;
        plat_y     = '0;
        plat_valid = '0;
    endtask

    initial begin
        int cx, cy;
        rst  = 1'b1;
        tick = 1'b0;
        doodle_x = '0;
        doodle_y = '0;
        clear_plats();
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs("reset");
        check("reset.busy", int'(busy), 0);
        rst = 1'b0;

        plat_x[0] = 11'd400; plat_y[0] = 10'd500; plat_valid[0] = 1'b1;
        run_frame("prime", 420, 400, 0, 0);
        check("prime.nohit", int'(collision), 0);
        run_frame("land", 420, 430, 0, 0);
        check("land.coll", int'(collision), 1);
        check("land.g1", int'(ground[1]), 400);
        check("land.g0", int'(ground[0]), 500);
        check("land.idx", int'(hit_index), 0);

        run_frame("rise", 420, 400, 0, 0);
        check("rise.g0", int'(ground[0]), 500);
        run_frame("xmiss", 300, 430, 0, 0);
        check("xmiss.coll", int'(collision), 0);

        clear_plats();
        plat_x[3] = 11'd400; plat_y[3] = 10'd495; plat_valid[3] = 1'b1;
        plat_x[1] = 11'd400; plat_y[1] = 10'd505; plat_valid[1] = 1'b1;
        run_frame("prio_a", 420, 410, 0, 0);
        run_frame("prio_b", 420, 430, 0, 0);
        check("prio.idx", int'(hit_index), 3);
        check("prio.g0", int'(ground[0]), 495);

        clear_plats();
        plat_x[2] = 11'd410; plat_y[2] = 10'd500; plat_valid[2] = 1'b1;
        plat_x[5] = 11'd380; plat_y[5] = 10'd500; plat_valid[5] = 1'b1;
        run_frame("eq_a", 420, 410, 0, 0);
        run_frame("eq_b", 420, 430, 0, 0);
        check("eq.idx", int'(hit_index), 2);

        clear_plats();
        run_frame("floor_a", 420, 680, 0, 0);
        run_frame("floor_b", 420, 690, 0, 0);
        check("floor.coll", int'(collision), 1);
        check("floor.g0", int'(ground[0]), 767);
        check("floor.idx", int'(hit_index), N);

        plat_x[0] = 11'd400; plat_y[0] = 10'd500; plat_valid[0] = 1'b1;
        run_frame("dtick_a", 420, 400, 0, 0);
        run_frame("dtick_b", 420, 430, 4, 0);
        run_frame("abort", 420, 400, 0, 5);
        run_frame("reprime", 420, 430, 0, 0);
        check("reprime.coll", int'(collision), 0);

        cy = 500;
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 3) == 0) cy = $urandom_range(300, 720);
            else cy = cy + $urandom_range(0, 50) - 15;
            if (cy < 300) cy = 300;
            if (cy > 720) cy = 720;
            cx = $urandom_range(350, 500);
            for (int i = 0; i < N; i++) begin
                plat_x[i]     = 11'($urandom_range(300, 550));
                plat_y[i]     = 10'($urandom_range(cy + 50, cy + 140));
                plat_valid[i] = 1'($urandom_range(0, 1));
                if (i > 0 && $urandom_range(0, 3) == 0) plat_y[i] = plat_y[0];
            end
            if ($urandom_range(0, 7) == 0) plat_valid = '0;
            run_frame($sformatf("rnd%0d", f), cx, cy, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
